speaker_tone_out: RTL and testbench

Consumer end of the note-divider interface. Takes the 20-bit `note_div` period word produced by the key-to-note controller and turns it into a square-wave tone. Serializes that tone as 16-bit left-justified stereo samples to the PMOD audio DAC (CS4344-class). Sits between the note controller and the board audio pins.

---
 rtl/audio_pkg.sv | 46 ++++
 rtl/speaker_tone_out_phase.sv | 67 ++++++
 rtl/speaker_tone_out.sv | 83 ++++++++
 tb/tb_speaker_tone_out.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared constants and helpers for the speaker tone output path.
//   - Audio counter width and the counter bits that become the DAC clocks.
//   - Sample and note-divider widths, silence threshold.
//   - Tone level encoding and the level-to-sample mapping.
package audio_pkg;

    localparam int unsigned ACNT_W     = 9;
    localparam int unsigned MCLK_BIT   = 1;
    localparam int unsigned SCK_BIT    = 3;
    localparam int unsigned LRCK_BIT   = 8;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned NOTE_DIV_W = 20;

    // acnt[7:4] selects the bit slot inside one 256-cycle channel half
    localparam int unsigned SLOT_LSB   = 4;
    localparam int unsigned SLOT_MSB   = 7;

    // note_div below this value means silence
    localparam logic [NOTE_DIV_W-1:0] SILENCE_THRESH = 20'd2;

    typedef enum logic [1:0] {
        TONE_SILENT,
        TONE_HIGH,
        TONE_LOW
    } tone_level_e;

    function automatic tone_level_e tone_level(input logic silent, input logic ph);
        if (silent) begin
            return TONE_SILENT;
        end
        return ph ? TONE_HIGH : TONE_LOW;
    endfunction

    function automatic logic [SAMPLE_W-1:0] level_to_sample(
        input tone_level_e         lvl,
        input logic [SAMPLE_W-1:0] amp
    );
        case (lvl)
            TONE_HIGH: return amp;
            TONE_LOW:  return SAMPLE_W'(~amp + 1'b1);
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/speaker_tone_out_phase.sv
// tone_phase_gen
//   Square-wave phase generator driven by a period word in clk cycles.
//   Ports:
//     clk      in  system clock (rising edge)
//     rst      in  synchronous active-high reset
//     note_div in  tone period in clk cycles; 0 or 1 means silence
//     ph       out 1 for the first floor(note_div/2) cycles of each period
//     silent   out 1 while note_div is below the silence threshold
module tone_phase_gen
    import audio_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NOTE_DIV_W-1:0] note_div,
    output logic                  ph,
    output logic                  silent
);

    logic [NOTE_DIV_W-1:0] r_tcnt;
    logic [NOTE_DIV_W-1:0] r_note_div_q;
    logic                  r_ph;
    logic                  r_silent;

    logic [NOTE_DIV_W-1:0] w_tcnt_nxt;
    logic [NOTE_DIV_W-1:0] w_half;
    logic [NOTE_DIV_W-1:0] w_last;
    logic                  w_silent_nxt;
    logic                  w_changed;
    logic                  w_ph_nxt;

    always_comb begin
        w_silent_nxt = (note_div < SILENCE_THRESH);
        w_changed    = (note_div != r_note_div_q);
        w_half       = note_div >> 1;
        w_last       = note_div - NOTE_DIV_W'(1);
        w_tcnt_nxt   = '0;
        w_ph_nxt     = 1'b0;
        if (!w_silent_nxt) begin
            // a new period word restarts the phase so no truncated period is carried over
            if (w_changed || (r_tcnt == w_last)) begin
                w_tcnt_nxt = '0;
            end else begin
                w_tcnt_nxt = r_tcnt + NOTE_DIV_W'(1);
            end
            // ph is registered from the next count so it stays aligned with tcnt
            w_ph_nxt = (w_tcnt_nxt < w_half);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt       <= '0;
            r_note_div_q <= '0;
            r_ph         <= 1'b0;
            r_silent     <= 1'b1;
        end else begin
            r_tcnt       <= w_tcnt_nxt;
            r_note_div_q <= note_div;
            r_ph         <= w_ph_nxt;
            r_silent     <= w_silent_nxt;
        end
    end

    assign ph     = r_ph;
    assign silent = r_silent;

endmodule

// File: rtl/speaker_tone_out.sv
// speaker_tone_out
//   Turns a note period word into a square-wave tone and serializes it as
//   16-bit left-justified stereo samples for a CS4344-class DAC.
//   Ports:
//     clk        in  system clock (rising edge)
//     rst        in  synchronous active-high reset
//     note_div   in  tone period in clk cycles; 0 or 1 means silence
//     audio_mclk out DAC master clock, clk/4
//     audio_sck  out DAC bit clock, clk/16
//     audio_lrck out DAC word select, clk/512 (0 = left, 1 = right)
//     audio_sdin out DAC serial data, MSB first
module speaker_tone_out
    import audio_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] AMPLITUDE = 16'h4000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NOTE_DIV_W-1:0] note_div,
    output logic                  audio_mclk,
    output logic                  audio_sck,
    output logic                  audio_lrck,
    output logic                  audio_sdin
);

    logic [ACNT_W-1:0]   r_acnt;
    logic [SAMPLE_W-1:0] r_frame_sample;
    logic                r_mclk;
    logic                r_sck;
    logic                r_lrck;
    logic                r_sdin;

    logic [ACNT_W-1:0]   w_acnt_nxt;
    logic [SAMPLE_W-1:0] w_cur;
    logic [SAMPLE_W-1:0] w_frame_nxt;
    logic [3:0]          w_bit_sel;
    logic                w_frame_wrap;
    logic                w_ph;
    logic                w_silent;

    tone_phase_gen u_phase (
        .clk      (clk),
        .rst      (rst),
        .note_div (note_div),
        .ph       (w_ph),
        .silent   (w_silent)
    );

    always_comb begin
        w_acnt_nxt   = r_acnt + ACNT_W'(1);
        w_frame_wrap = (r_acnt == '1);
        w_cur        = level_to_sample(tone_level(w_silent, w_ph), AMPLITUDE);
        w_frame_nxt  = w_frame_wrap ? w_cur : r_frame_sample;
        // slot k carries bit 15-k, i.e. the bitwise inverse of the slot number
        w_bit_sel    = ~w_acnt_nxt[SLOT_MSB:SLOT_LSB];
    end

    // Clock outputs and serial data are registered from the same next-state
    // as acnt so every DAC pin changes on one edge, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acnt         <= '0;
            r_frame_sample <= '0;
            r_mclk         <= 1'b0;
            r_sck          <= 1'b0;
            r_lrck         <= 1'b0;
            r_sdin         <= 1'b0;
        end else begin
            r_acnt         <= w_acnt_nxt;
            r_frame_sample <= w_frame_nxt;
            r_mclk         <= w_acnt_nxt[MCLK_BIT];
            r_sck          <= w_acnt_nxt[SCK_BIT];
            r_lrck         <= w_acnt_nxt[LRCK_BIT];
            r_sdin         <= w_frame_nxt[w_bit_sel];
        end
    end

    assign audio_mclk = r_mclk;
    assign audio_sck  = r_sck;
    assign audio_lrck = r_lrck;
    assign audio_sdin = r_sdin;

endmodule

// File: tb/tb_speaker_tone_out.sv
module tb_speaker_tone_out;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] note_div = '0;
    logic        audio_mclk;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdin;

    speaker_tone_out #(.AMPLITUDE(16'h4000)) dut (
        .clk        (clk),
        .rst        (rst),
        .note_div   (note_div),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // edge bookkeeping for the reference model
    int e        = 0;
    int er       = 0;
    bit last_rst = 1'b0;
    bit seen_rst = 1'b0;

    // reference model: tone of period m_nd, phase restarted at edge m_e0
    int m_nd = 0;
    int m_e0 = 0;

    // DAC-side decoder state
    logic [15:0] exp_frame = '0;
    logic [15:0] cur_prev  = '0;
    logic [15:0] word      = '0;
    int          bits      = 0;
    int          n_words   = 0;
    logic        prev_sck  = 1'b0;
    logic        prev_sdin = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    always @(posedge clk) begin
        e = e + 1;
        last_rst = rst;
        if (rst) begin
            er = e;
            seen_rst = 1'b1;
        end
    end

    always @(negedge clk) begin
        int a;
        int t;
        logic [15:0] cur_now;
        if (seen_rst) begin
            a = (e - er) % 512;
            chk("mclk", audio_mclk, (a >> 1) & 1);
            chk("sck",  audio_sck,  (a >> 3) & 1);
            chk("lrck", audio_lrck, (a >> 8) & 1);
            chk("acnt", dut.r_acnt, a);
            if (last_rst) begin
                chk("rst_sdin", audio_sdin, 0);
                chk("rst_tcnt", dut.u_phase.r_tcnt, 0);
                chk("rst_ph", dut.w_ph, 0);
                exp_frame = '0;
                cur_prev  = '0;
                word      = '0;
                bits      = 0;
                prev_sck  = 1'b0;
                prev_sdin = 1'b0;
            end else begin
                if (m_nd < 2) begin
                    chk("tcnt", dut.u_phase.r_tcnt, 0);
                    chk("ph", dut.w_ph, 0);
                    cur_now = 16'h0000;
                end else begin
                    t = (e - m_e0) % m_nd;
                    chk("tcnt", dut.u_phase.r_tcnt, t);
                    chk("ph", dut.w_ph, (t < m_nd / 2) ? 1 : 0);
                    cur_now = (t < m_nd / 2) ? 16'h4000 : 16'hC000;
                end
                // frame value is the tone level on the last cycle before the boundary
                if (a == 0) exp_frame = cur_prev;
                if (audio_sck && prev_sck)
                    chk("sdin_stable_sck_high", audio_sdin, prev_sdin);
                if (audio_sck && !prev_sck) begin
                    word = {word[14:0], audio_sdin};
                    bits++;
                    if (bits == 16) begin
                        chk(audio_lrck ? "dac_word_R" : "dac_word_L", word, exp_frame);
                        bits = 0;
                        n_words++;
                    end
                end
                prev_sck  = audio_sck;
                prev_sdin = audio_sdin;
                cur_prev  = cur_now;
            end
        end
    end

    // call only just after a negedge
    task automatic set_nd_now(input logic [19:0] v);
        if (v != note_div) m_e0 = e + 1;
        note_div = v;
        m_nd = int'(v);
    endtask

    task automatic set_nd(input logic [19:0] v);
        @(negedge clk);
        #1;
        set_nd_now(v);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (n) @(negedge clk);
        chk("in_rst_mclk", audio_mclk, 0);
        chk("in_rst_sck", audio_sck, 0);
        chk("in_rst_lrck", audio_lrck, 0);
        chk("in_rst_sdin", audio_sdin, 0);
        #1 rst = 1'b0;
        m_e0 = e + 1;
    endtask

    typedef struct {
        logic [19:0] nd;
        int          cycles;
        int          exp_high;
        int          exp_period;  // 0 when no second rise falls inside the window
    } vec_t;

    vec_t tbl[8];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int h;
        int p;
        int w0;
        bit seen0;
        logic phv;
        logic [19:0] v;

        tbl[0] = '{20'd76336, 38300, 38168, 0};
        tbl[1] = '{20'd600,   2000,  300,   600};
        tbl[2] = '{20'd1001,  3000,  500,   1001};
        tbl[3] = '{20'd3,     1100,  1,     3};
        tbl[4] = '{20'd2,     1100,  1,     2};
        tbl[5] = '{20'd0,     1100,  0,     0};
        tbl[6] = '{20'd1,     1100,  0,     0};
        tbl[7] = '{20'd513,   1600,  256,   513};

        note_div = 20'd76336;
        m_nd = 76336;
        do_reset(3);

        // clock start-up after reset release
        i = 0;
        while (!audio_mclk && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("mclk_first_rise", i, 2);
        while (!audio_lrck && i < 600) begin
            @(negedge clk);
            i++;
        end
        chk("lrck_first_rise", i, 256);

        // note change mid-period at tcnt = 1000
        i = 0;
        while (((e - m_e0) % m_nd) != 1000 && i < 80000) begin
            @(negedge clk);
            i++;
        end
        chk("pre_change_tcnt", dut.u_phase.r_tcnt, 1000);
        #1 set_nd_now(20'd40486);
        @(negedge clk);
        chk("restart_tcnt", dut.u_phase.r_tcnt, 0);
        repeat (1500) @(negedge clk);

        // table of period words: measure high time and period of ph
        for (int k = 0; k < 8; k++) begin
            set_nd(tbl[k].nd);
            h = 0;
            p = 0;
            seen0 = 1'b0;
            for (int c = 0; c < tbl[k].cycles; c++) begin
                @(negedge clk);
                phv = dut.w_ph;
                if (!seen0) begin
                    if (phv) h++;
                    else seen0 = 1'b1;
                end else if (phv && p == 0) begin
                    p = c;
                end
            end
            chk($sformatf("tbl%0d_high", k), h, tbl[k].exp_high);
            chk($sformatf("tbl%0d_period", k), p, tbl[k].exp_period);
        end

        // largest period word
        set_nd(20'hFFFFF);
        repeat (1100) @(negedge clk);

        // randomized period words against the model
        for (int r = 0; r < 6; r++) begin
            v = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(0, 1))
                                             : 20'($urandom_range(2, 4000));
            set_nd(v);
            repeat ($urandom_range(600, 1400)) @(negedge clk);
        end

        // reset in the right-channel half of a frame
        set_nd(20'd1234);
        i = 0;
        while (((e - er) % 512) != 300 && i < 600) begin
            @(negedge clk);
            i++;
        end
        chk("midrst_lrck_before", audio_lrck, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_lrck", audio_lrck, 0);
        chk("midrst_sdin", audio_sdin, 0);
        chk("midrst_acnt", dut.r_acnt, 0);
        #1 rst = 1'b0;
        m_e0 = e + 1;
        w0 = n_words;
        repeat (1200) @(negedge clk);
        chk("words_after_midrst", (n_words - w0) >= 4 ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
